// File: rtl/fire6_squeeze_mac.sv
// fire6_squeeze_mac: NUM-wide 1x1 squeeze MAC over IN_CH channels with ReLU/saturating quantiser.
module fire6_squeeze_mac #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8,
  parameter int ADDR  = 11,
  parameter int NUM   = 64,
  parameter int IN_CH = 256,
  parameter int ACC_W = 40
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [WIDTH-1:0] act_data,
  input  logic                    act_valid,
  output logic                    act_ready,
  output logic [ADDR-1:0]         rom_addr,
  input  logic signed [WIDTH-1:0] rom_data [NUM],
  output logic [WIDTH-1:0]        out_data [NUM],
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy
);
  typedef enum logic [1:0] {ACCUM, FLUSH, QUANT, OUT} state_t;
  state_t state, state_nx;
  logic [ADDR-1:0] ch_cnt;
  logic signed [WIDTH-1:0] act_q;
  logic mac_en, first_q, accept, last;
  logic signed [ACC_W-1:0] acc [NUM];
  logic signed [ACC_W-1:0] sh [NUM];
  logic signed [2*WIDTH-1:0] prod [NUM];
  logic [WIDTH-1:0] quant [NUM];
  assign act_ready = state == ACCUM;
  assign accept    = act_valid && act_ready;
  assign last      = ch_cnt == ADDR'(IN_CH - 1);
  assign rom_addr  = ch_cnt;
  assign out_valid = state == OUT;
  assign busy      = state != ACCUM || ch_cnt != '0;
  always_comb begin
    state_nx = (state == ACCUM) ? ((accept && last) ? FLUSH : ACCUM) :
               (state == FLUSH) ? QUANT :
               (state == QUANT) ? OUT :
               (out_ready ? ACCUM : OUT);
    for (int k = 0; k < NUM; k++) begin
      prod[k]  = act_q * rom_data[k];
      sh[k]    = acc[k] >>> FRAC;
      // non-negative values with any bit above the sign position of the output saturate
      quant[k] = sh[k][ACC_W-1] ? '0 :
                 (|sh[k][ACC_W-2:WIDTH-1]) ? {1'b0, {(WIDTH-1){1'b1}}} : sh[k][WIDTH-1:0];
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ACCUM;
      ch_cnt  <= '0;
      act_q   <= '0;
      mac_en  <= 1'b0;
      first_q <= 1'b0;
      for (int k = 0; k < NUM; k++) begin
        acc[k]      <= '0;
        out_data[k] <= '0;
      end
    end else begin
      state  <= state_nx;
      mac_en <= accept;
      if (accept) begin
        ch_cnt  <= last ? '0 : ch_cnt + 1'b1;
        act_q   <= act_data;
        first_q <= ch_cnt == '0;
      end
      for (int k = 0; k < NUM; k++) begin
        if (mac_en) acc[k] <= (first_q ? '0 : acc[k]) + ACC_W'(prod[k]);
        if (state == QUANT) out_data[k] <= quant[k];
      end
    end
  end
endmodule

// File: tb/tb_fire6_squeeze_mac.sv
// tb_fire6_squeeze_mac: directed self-checking bench for fire6_squeeze_mac.
module tb_fire6_squeeze_mac;
  localparam int NUM = 64;
  localparam int IN_CH = 256;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic signed [15:0] act_data = '0;
  logic act_valid = 1'b0;
  logic act_ready;
  logic [10:0] rom_addr;
  logic signed [15:0] rom_data [NUM];
  logic [15:0] out_data [NUM];
  logic out_valid;
  logic out_ready = 1'b1;
  logic busy;
  int mode = 0;
  int n_vec = 0;
  int n_err = 0;

  fire6_squeeze_mac dut (
    .clk(clk), .rst_n(rst_n), .act_data(act_data), .act_valid(act_valid),
    .act_ready(act_ready), .rom_addr(rom_addr), .rom_data(rom_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  // weight ROM model: mode 0 all 1.0, mode 1 +1.0/-1.0 alternating, mode 2 all max
  always @(posedge clk)
    for (int k = 0; k < NUM; k++)
      rom_data[k] <= (mode == 2) ? 16'sh7FFF : (mode == 1 && k[0]) ? 16'shFF00 : 16'sh0100;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [15:0] a, input bit gaps, input int n);
    for (int i = 0; i < n; i++) begin
      if (gaps)
        while ($urandom_range(0, 2) == 0) begin
          act_valid = 1'b0;
          @(posedge clk); #1;
          chk("gap_addr", 32'(rom_addr), 32'(i));
        end
      act_valid = 1'b1;
      act_data  = a;
      @(posedge clk); #1;
    end
    act_valid = 1'b0;
  endtask

  task automatic expect_out(input logic [15:0] even_v, input logic [15:0] odd_v);
    chk("flush_valid", 32'(out_valid), 0);
    chk("flush_ready", 32'(act_ready), 0);
    @(posedge clk); #1;
    chk("quant_valid", 32'(out_valid), 0);
    @(posedge clk); #1;
    chk("out_valid", 32'(out_valid), 1);
    chk("out_busy", 32'(busy), 1);
    for (int k = 0; k < NUM; k++)
      chk($sformatf("out_data[%0d]", k), 32'(out_data[k]), 32'(k[0] ? odd_v : even_v));
  endtask

  task automatic handshake();
    @(posedge clk); #1;
    chk("hs_valid", 32'(out_valid), 0);
    chk("hs_ready", 32'(act_ready), 1);
    chk("hs_busy", 32'(busy), 0);
    chk("hs_addr", 32'(rom_addr), 0);
  endtask

  task automatic pixel(input logic [15:0] a, input bit gaps, input logic [15:0] ev, input logic [15:0] ov);
    send(a, gaps, IN_CH);
    expect_out(ev, ov);
    handshake();
  endtask

  initial begin
    #1;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_addr", 32'(rom_addr), 0);
    chk("rst_data0", 32'(out_data[0]), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_ready", 32'(act_ready), 1);

    mode = 0; pixel(16'h0010, 1'b0, 16'h1000, 16'h1000);
    mode = 1; pixel(16'h0020, 1'b0, 16'h2000, 16'h0000);
    mode = 0; pixel(16'h0100, 1'b0, 16'h7FFF, 16'h7FFF);
    mode = 2; pixel(16'h7FFF, 1'b0, 16'h7FFF, 16'h7FFF);
    mode = 0; pixel(16'h0010, 1'b1, 16'h1000, 16'h1000);

    out_ready = 1'b0;
    send(16'h0010, 1'b0, IN_CH);
    expect_out(16'h1000, 16'h1000);
    act_valid = 1'b1;
    act_data  = 16'h0040;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_data0", 32'(out_data[0]), 32'h1000);
      chk("bp_data63", 32'(out_data[63]), 32'h1000);
      chk("bp_ready", 32'(act_ready), 0);
      chk("bp_addr", 32'(rom_addr), 0);
    end
    out_ready = 1'b1;
    act_valid = 1'b0;
    handshake();

    pixel(16'h0010, 1'b0, 16'h1000, 16'h1000);
    pixel(16'h0020, 1'b0, 16'h2000, 16'h2000);
    pixel(16'h0040, 1'b0, 16'h4000, 16'h4000);

    send(16'h0010, 1'b0, 100);
    chk("mid_addr", 32'(rom_addr), 100);
    chk("mid_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", 32'(out_valid), 0);
    chk("mrst_addr", 32'(rom_addr), 0);
    chk("mrst_busy", 32'(busy), 0);
    for (int k = 0; k < NUM; k++)
      chk($sformatf("mrst_data[%0d]", k), 32'(out_data[k]), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    pixel(16'h0010, 1'b0, 16'h1000, 16'h1000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
